// File: rtl/bit_reverse_reorder.sv
// ---------------------------------------------------------------------------
// bit_reverse_reorder
//
// Output reorder buffer for a radix-2^2 SDF FFT pipeline. The FFT delivers
// each N-point frame in bit-reversed index order. This block stores the frame
// in one half of a ping-pong memory, then streams it out in natural order
// (X[0] .. X[N-1]) while the next frame fills the other half.
//
// Parameters
//   WIDTH  bit width of each real/imag sample (two's complement)
//   LOG_N  log2 of the FFT length, N = 2**LOG_N
//
// Ports
//   clock    rising-edge system clock
//   reset    synchronous, active-high reset
//   di_en    input sample valid (gaps allowed)
//   di_re    input real part, bit-reversed order
//   di_im    input imag part
//   do_en    output sample valid
//   do_re    output real part, natural order
//   do_im    output imag part
//   do_last  high with output index N-1 of each frame
// ---------------------------------------------------------------------------
module bit_reverse_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_last
);

    localparam int                 N        = 1 << LOG_N;
    localparam logic [LOG_N-1:0]   LAST_IDX = '1;

    typedef enum logic {IDLE, READ} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [LOG_N-1:0]   wr_cnt;
    logic               wr_bank;
    logic [LOG_N-1:0]   rd_cnt;
    logic               rd_bank;

    logic               wr_en;
    logic               frame_done;
    logic               rd_active;
    logic               rd_issue;
    logic               rd_wrap;

    logic [2*WIDTH-1:0] mem [2*N];
    logic [2*WIDTH-1:0] rd_data;
    logic               rd_vld;
    logic               rd_last;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] idx);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = idx[LOG_N-1-i];
        end
        return r;
    endfunction

    // Samples offered while reset is high are dropped.
    assign wr_en      = di_en && !reset;
    assign frame_done = wr_en && (wr_cnt == LAST_IDX);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (di_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_IDX) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Memory: synchronous write and registered read. The read bank is never
    // the write bank, so there is no read/write hazard on the same word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_bank, wr_cnt}] <= {di_re, di_im};
        end
        if (rd_issue) begin
            rd_data <= mem[{rd_bank, bitrev(rd_cnt)}];
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_done) state_nxt = READ;
            READ: if (rd_cnt == LAST_IDX) state_nxt = frame_done ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_active = (state == READ);
        rd_issue  = rd_active;
        rd_wrap   = rd_active && (rd_cnt == LAST_IDX);
    end

    // A frame completing on the final read issue restarts the readout at
    // once on the new bank, giving back-to-back output frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (frame_done && (!rd_active || rd_wrap)) begin
            rd_cnt  <= '0;
            rd_bank <= wr_bank;
        end else if (rd_active) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: issue flags follow the memory read by one cycle,
    // output registers load one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            rd_vld  <= rd_issue;
            rd_last <= rd_wrap;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !rd_vld) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            do_en   <= 1'b1;
            do_last <= rd_last;
            do_re   <= rd_data[2*WIDTH-1:WIDTH];
            do_im   <= rd_data[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// ---------------------------------------------------------------------------
// tb_bit_reverse_reorder
//
// Randomized bench for bit_reverse_reorder (WIDTH=16, LOG_N=4). A reference
// model keeps a per-edge schedule of expected outputs: when a frame's last
// sample is written at edge e, natural-order output k is due at edge e+2+k.
// A reset at edge r cancels everything due at r or later and discards any
// partial input frame. Every edge without a scheduled output must show
// all-zero outputs.
// ---------------------------------------------------------------------------
module tb_bit_reverse_reorder;

    localparam int WIDTH = 16;
    localparam int LOG_N = 4;
    localparam int N     = 1 << LOG_N;

    logic             clock;
    logic             reset;
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;

    bit_reverse_reorder #(.WIDTH(WIDTH), .LOG_N(LOG_N)) dut (
        .clock  (clock),
        .reset  (reset),
        .di_en  (di_en),
        .di_re  (di_re),
        .di_im  (di_im),
        .do_en  (do_en),
        .do_re  (do_re),
        .do_im  (do_im),
        .do_last(do_last)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always @(posedge clock) edge_n++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h want %0h", tag, edge_n, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] exp_re   [int];
    logic [WIDTH-1:0] exp_im   [int];
    bit               exp_last [int];
    logic [WIDTH-1:0] frm_re   [N];
    logic [WIDTH-1:0] frm_im   [N];
    int               pos = 0;

    function automatic int brev(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < LOG_N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Drive one cycle's inputs (effective at the next rising edge) and update
    // the model for what that edge does.
    task automatic drive(input logic rst, input logic en, input logic [WIDTH-1:0] re,
                         input logic [WIDTH-1:0] im);
        int e;
        int keys[$];
        @(negedge clock);
        reset = rst;
        di_en = en;
        di_re = re;
        di_im = im;
        e = edge_n + 1;
        if (rst) begin
            pos = 0;
            foreach (exp_re[k]) if (k >= e) keys.push_back(k);
            foreach (keys[i]) begin
                exp_re.delete(keys[i]);
                exp_im.delete(keys[i]);
                exp_last.delete(keys[i]);
            end
        end else if (en) begin
            frm_re[pos] = re;
            frm_im[pos] = im;
            pos++;
            if (pos == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_re[e+2+k]   = frm_re[brev(k)];
                    exp_im[e+2+k]   = frm_im[brev(k)];
                    exp_last[e+2+k] = (k == N-1);
                end
                pos = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // Frame with values base+p / -(base+p); gap_mode 0 contiguous,
    // 1 pattern 1,0,0, 2 random gaps.
    task automatic send_frame(input int base, input int gap_mode, input int count);
        for (int p = 0; p < count; p++) begin
            drive(1'b0, 1'b1, WIDTH'(base + p), WIDTH'(-(base + p)));
            if (p != count - 1) begin
                if (gap_mode == 1) idle(2);
                else if (gap_mode == 2) idle($urandom_range(0, 2));
            end
        end
    endtask

    // ---------------- output checker ----------------
    always @(negedge clock) begin
        if (edge_n >= 1) begin
            if (exp_re.exists(edge_n)) begin
                chk("do_en", 64'(do_en), 64'd1);
                chk("do_re", 64'(do_re), 64'(exp_re[edge_n]));
                chk("do_im", 64'(do_im), 64'(exp_im[edge_n]));
                chk("do_last", 64'(do_last), 64'(exp_last[edge_n]));
            end else begin
                chk("idle_out", {30'd0, do_en, do_last, do_re, do_im}, 64'd0);
            end
            chk("collision", 64'(dut.frame_done && dut.rd_active && (dut.rd_cnt != 4'(N-1))), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;

        // reset held with di_en high and random data
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
        idle(5);

        // single contiguous frame p / -p
        send_frame(0, 0, N);
        idle(20);

        // gapped 1,0,0 pattern
        send_frame(0, 1, N);
        idle(20);

        // three back-to-back frames
        send_frame(0, 0, N);
        send_frame(100, 0, N);
        send_frame(200, 0, N);
        idle(20);

        // reset after 7 inputs of frame A, then frame B
        send_frame(500, 0, 7);
        drive(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
        send_frame(300, 0, N);
        idle(20);

        // reset five outputs into a readout, then recover
        send_frame(400, 0, N);
        idle(6);
        drive(1'b1, 1'b0, '0, '0);
        idle(20);
        send_frame(600, 2, N);
        idle(20);

        // full-scale bit patterns at positions 0..3
        drive(1'b0, 1'b1, 16'h8000, 16'h7FFF);
        drive(1'b0, 1'b1, 16'h7FFF, 16'h8000);
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0001);
        drive(1'b0, 1'b1, 16'h0001, 16'hFFFF);
        for (int p = 4; p < N; p++) drive(1'b0, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
        idle(20);

        // random data, random gaps, occasional random reset
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 60) == 0) drive(1'b1, 1'(($urandom)), WIDTH'($urandom), WIDTH'($urandom));
                drive(1'b0, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_reverse_reorder.md
Name: bit_reverse_reorder

Overview:
- Output reorder buffer for the radix-2^2 SDF FFT pipeline.
- Sits after the last butterfly/twiddle stage.
- The FFT emits each N-point frame in bit-reversed index order. This block stores the frame and streams it out in natural order (X[0], X[1], ... X[N-1]).
- Ping-pong memory of 2*N complex entries, so one frame is written while the previous frame is read.

Parameters:
- WIDTH, 16, bit width of each real/imag sample (two's complement).
- LOG_N, 6, log2 of FFT length; N = 2**LOG_N points per frame.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- di_en  input  1  input sample valid; one sample per asserted cycle, gaps allowed.
- di_re  input  WIDTH  input data, real (bit-reversed order).
- di_im  input  WIDTH  input data, imag.
- do_en  output  1  output sample valid.
- do_re  output  WIDTH  output data, real (natural order).
- do_im  output  WIDTH  output data, imag.
- do_last  output  1  high with the final (index N-1) sample of each output frame.

Behaviour:
- Reset: synchronous, active-high.
  - Clears wr_cnt, wr_bank, rd_cnt, rd_bank, rd_active.
  - Outputs do_en=0, do_last=0, do_re=0, do_im=0 from the first edge at which reset is sampled high.
- Memory: 2*N words of 2*WIDTH bits.
  - Address = {bank, LOG_N-bit index}.
  - Synchronous write; synchronous (registered) read.
  - No data-dependent arithmetic: values pass through bit-exact, sign preserved.
- Write side:
  - Each cycle with di_en=1 writes {di_re, di_im} to mem[{wr_bank, wr_cnt}], then wr_cnt increments modulo N.
  - When a write occurs with wr_cnt=N-1: wr_cnt wraps to 0, wr_bank toggles, and a one-cycle frame_done pulse is raised.
  - di_en=0 cycles are ignored: no counter change, frame position held.
- Read side, states IDLE and READ:
  - IDLE -> READ on frame_done. rd_bank captures the just-completed bank (old wr_bank); rd_cnt=0.
  - In READ, each cycle issues read address {rd_bank, bitrev(rd_cnt)} and increments rd_cnt.
  - bitrev reverses the LOG_N index bits, so output k = input sample at position bitrev(k).
  - READ -> IDLE after issuing rd_cnt=N-1.
  - Output registers load one cycle after each read issue: do_en=1, do_re/do_im = memory data, do_last=1 when the issued index was N-1.
  - When no read data is valid: do_en=0, do_last=0, do_re=do_im=0.
- Latency and throughput:
  - Last input sample write at edge t -> first output (do_en=1) at edge t+2.
  - Output frame is N consecutive do_en cycles; do_last at edge t+N+1.
- Bank collision safety:
  - The next frame needs at least N input cycles, so its frame_done comes no earlier than edge t+N. That is the edge of the final read issue of the current frame.
  - The read bank is therefore never the write bank.
  - Requirement if frame_done coincides with the last read issue: READ restarts with the new bank and rd_cnt=0 on the following cycle, giving back-to-back output frames with no gap.
  - Bench assertion: frame_done never occurs while rd_cnt < N-1 in READ.
- Reset mid-operation:
  - A partial input frame is discarded; the next di_en sample is position 0 of a fresh frame in bank 0.
  - An in-progress readout is aborted; do_en=0 from the reset edge onward.
  - Memory contents are not cleared and are never read before being rewritten.
- di_en asserted during reset: ignored.

Test Plan:
- Reset values: hold reset 3 cycles with di_en=1 and random data -> do_en=do_last=0, do_re=do_im=0 throughout and after release, no output.
- Single frame, LOG_N=4: contiguous di_re=p, di_im=-p for p=0..15 -> starting 2 cycles after the last input, 16 consecutive outputs with do_re = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 and do_im = negated values; do_last only on the 16th output.
- Gapped input, LOG_N=4: same frame with di_en toggling 1,0,0,1,... -> identical output sequence, output burst contiguous, start 2 cycles after the final input.
- Back-to-back frames: three contiguous frames (values p, 100+p, 200+p) -> 48 contiguous do_en cycles, no gap, each frame correctly bit-reverse reordered, do_last every 16th.
- Reset mid-operation: reset after 7 inputs of frame A, then a full frame B; separately, reset 5 outputs into a readout -> partial A never appears, B emitted correctly; do_en drops to 0 at the reset edge.
- Full-scale pass-through, WIDTH=16: samples 0x8000, 0x7FFF, 0xFFFF, 0x0001 at positions 0..3 -> exact bit patterns appear at natural indices 0, 8, 4, 12 (0x8000 at 0, 0x7FFF at 8, 0xFFFF at 4, 0x0001 at 12), no sign or width corruption.
